// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, baud table and oversampling constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  typedef enum logic [1:0] {PAR_NONE, PAR_EVEN, PAR_ODD, PAR_NONE3} parity_mode_t;
  localparam int OVERSAMPLE = 16;
  localparam logic [2:0][3:0] SAMPLE_TICKS = {4'd9, 4'd8, 4'd7};
  localparam int DIV_W = 24;
  localparam logic [7:0][16:0] BAUD_TABLE = {17'd115200, 17'd57600, 17'd38400, 17'd19200,
                                             17'd9600, 17'd4800, 17'd1200, 17'd300};
  function automatic logic [DIV_W-1:0] baud_div(input int clk_hz, input logic [2:0] code);
    int b;
    b = int'(BAUD_TABLE[code]);
    return DIV_W'((clk_hz + b * OVERSAMPLE / 2) / (b * OVERSAMPLE));
  endfunction
endpackage

// File: rtl/uart_rx_buffered_if.sv
// uart_rx_buffered_if: valid/ready receive stream carrying data plus error flags
interface uart_rx_buffered_if #(parameter int DATA_BITS = 8);
  logic [DATA_BITS-1:0] rx_data;
  logic rx_ferror;
  logic rx_perror;
  logic rx_valid;
  logic rx_ready;
  modport master (output rx_data, rx_ferror, rx_perror, rx_valid, input rx_ready);
  modport slave (input rx_data, rx_ferror, rx_perror, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO, push into a full FIFO succeeds only alongside a pop
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic [WIDTH-1:0] push_data,
  input  logic pop,
  output logic [WIDTH-1:0] pop_data,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign pop_data = mem[rd_ptr];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
endmodule

// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered: 16x oversampled UART receiver with majority vote feeding a valid/ready FIFO
module uart_rx_buffered import uart_pkg::*; #(
  parameter int CLK_HZ = 50000000,
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_en,
  input  logic rxd,
  input  logic [2:0] baud_select,
  input  logic [1:0] parity_mode,
  uart_rx_buffered_if.master rx,
  output logic rx_overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int W = DATA_BITS + 2;
  rx_state_t state, state_next;
  parity_mode_t pm;
  logic [2:0] sync;
  logic [DIV_W-1:0] div_q, baud_cnt;
  logic [3:0] tick_cnt;
  logic [2:0] bit_idx;
  logic [1:0] samples;
  logic [DATA_BITS-1:0] shreg;
  logic perr, ferr;
  logic rxs, start_edge, tick, bit_done, bit_val, parity_on, last_data, last_stop;
  logic push, full, empty;
  logic [W-1:0] push_data, head;
  assign pm = parity_mode_t'(parity_mode);
  // sync[1:0] is the synchroniser, sync[2] the previous synchronised level for edge detect
  assign rxs = sync[1];
  assign start_edge = rx_en && sync[2] && !sync[1];
  assign tick = state != IDLE && baud_cnt == div_q - DIV_W'(1);
  assign bit_done = tick && tick_cnt == SAMPLE_TICKS[2];
  assign bit_val = (samples[0] & samples[1]) | (samples[0] & rxs) | (samples[1] & rxs);
  assign parity_on = pm == PAR_EVEN || pm == PAR_ODD;
  assign last_data = bit_idx == 3'(DATA_BITS - 1);
  assign last_stop = bit_idx == 3'(STOP_BITS - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_next;
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = start_edge ? START : IDLE;
      START:   state_next = bit_done ? (bit_val ? IDLE : DATA) : START;
      DATA:    state_next = bit_done && last_data ? (parity_on ? PARITY : STOP) : DATA;
      PARITY:  state_next = bit_done ? STOP : PARITY;
      STOP:    state_next = bit_done && last_stop ? IDLE : STOP;
      default: state_next = IDLE;
    endcase
    if (state != IDLE && !rx_en) state_next = IDLE;
  end
  always_comb begin
    push = state == STOP && bit_done && last_stop && rx_en;
    push_data = {ferr | ~bit_val, perr, shreg};
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      sync <= '1;
      div_q <= '0;
      baud_cnt <= '0;
      tick_cnt <= '0;
      bit_idx <= '0;
      samples <= '0;
      shreg <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      sync <= {sync[1:0], rxd};
      if (state == IDLE) begin
        baud_cnt <= '0;
        tick_cnt <= '0;
        bit_idx <= '0;
        perr <= 1'b0;
        ferr <= 1'b0;
        if (start_edge) div_q <= baud_div(CLK_HZ, baud_select);
      end else begin
        baud_cnt <= tick ? '0 : baud_cnt + 1'b1;
        if (tick) begin
          tick_cnt <= tick_cnt + 1'b1;
          if (tick_cnt == SAMPLE_TICKS[0]) samples[0] <= rxs;
          if (tick_cnt == SAMPLE_TICKS[1]) samples[1] <= rxs;
        end
        if (bit_done) begin
          bit_idx <= state_next == state ? bit_idx + 1'b1 : '0;
          if (state == DATA) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
          if (state == PARITY) perr <= (^shreg ^ bit_val) != (pm == PAR_ODD);
          if (state == STOP) ferr <= ferr | ~bit_val;
        end
      end
    end
  always_ff @(posedge clk or negedge reset)
    if (!reset) rx_overrun <= 1'b0;
    else if (!rx_en) rx_overrun <= 1'b0;
    else if (push && full && !(rx.rx_ready && !empty)) rx_overrun <= 1'b1;
  uart_rx_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .push_data(push_data),
    .pop(rx.rx_ready),
    .pop_data(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  assign {rx.rx_ferror, rx.rx_perror, rx.rx_data} = head;
  assign rx.rx_valid = !empty;
endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered: directed scenarios at 115200 baud (divider 27, 432 clk per bit)
module tb_uart_rx_buffered;
  localparam int BIT = 432;
  logic clk = 1'b0, reset = 1'b0, rx_en_a = 1'b1, rx_en_b = 1'b0, rxd = 1'b1;
  logic [2:0] baud_select = 3'd7;
  logic [1:0] parity_mode = 2'd0;
  logic overrun_a, overrun_b;
  logic [2:0] level_a, level_b;
  int checks = 0, errors = 0;
  uart_rx_buffered_if #(.DATA_BITS(8)) ifa ();
  uart_rx_buffered_if #(.DATA_BITS(7)) ifb ();
  uart_rx_buffered #(.CLK_HZ(50000000), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .rx_en(rx_en_a), .rxd(rxd), .baud_select(baud_select),
    .parity_mode(parity_mode), .rx(ifa), .rx_overrun(overrun_a), .fifo_level(level_a));
  uart_rx_buffered #(.CLK_HZ(50000000), .DATA_BITS(7), .STOP_BITS(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset), .rx_en(rx_en_b), .rxd(rxd), .baud_select(baud_select),
    .parity_mode(parity_mode), .rx(ifb), .rx_overrun(overrun_b), .fifo_level(level_b));
  always #10 clk = ~clk;

  task automatic drive_bits(input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rxd = bits[i];
      repeat (BIT) @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int nd, input int pbit, input logic [1:0] stops, input int ns);
    logic [15:0] v;
    int n;
    v = '0;
    n = 1;
    for (int i = 0; i < nd; i++) begin v[n] = d[i]; n++; end
    if (pbit >= 0) begin v[n] = pbit[0]; n++; end
    for (int i = 0; i < ns; i++) begin v[n] = stops[i]; n++; end
    drive_bits(v, n);
    rxd = 1'b1;
    repeat (16) @(negedge clk);
  endtask

  task automatic pop_entry(input bit sel, output logic ok, output logic [7:0] d, output logic fe, output logic pe);
    int n;
    n = 0;
    while (!(sel ? ifb.rx_valid : ifa.rx_valid) && n < 200) begin @(negedge clk); n++; end
    ok = sel ? ifb.rx_valid : ifa.rx_valid;
    d = sel ? {1'b0, ifb.rx_data} : ifa.rx_data;
    fe = sel ? ifb.rx_ferror : ifa.rx_ferror;
    pe = sel ? ifb.rx_perror : ifa.rx_perror;
    if (sel) ifb.rx_ready = 1'b1; else ifa.rx_ready = 1'b1;
    @(negedge clk);
    ifa.rx_ready = 1'b0;
    ifb.rx_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ifa.rx_data, ifa.rx_ferror, ifa.rx_perror, ifa.rx_valid, overrun_a, level_a} !== '0) begin
      errors++; $display("FAIL reset_a: got data=%h fe=%b pe=%b v=%b ovr=%b lvl=%0d want all 0",
        ifa.rx_data, ifa.rx_ferror, ifa.rx_perror, ifa.rx_valid, overrun_a, level_a);
    end
    checks++;
    if ({ifb.rx_data, ifb.rx_ferror, ifb.rx_perror, ifb.rx_valid, overrun_b, level_b} !== '0) begin
      errors++; $display("FAIL reset_b: got data=%h v=%b lvl=%0d want all 0", ifb.rx_data, ifb.rx_valid, level_b);
    end
    reset = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic;
    int n;
    n = 0;
    fork
      send_frame(8'hA5, 8, -1, 2'b11, 1);
      while (!ifa.rx_valid && n < 6000) begin @(negedge clk); n++; end
    join
    checks++;
    if (n !== 4161) begin errors++; $display("FAIL basic_latency: got %0d want 4161 clk from start edge to valid", n); end
    checks++;
    if ({ifa.rx_valid, ifa.rx_data, ifa.rx_ferror, ifa.rx_perror, level_a} !== {1'b1, 8'hA5, 1'b0, 1'b0, 3'd1}) begin
      errors++; $display("FAIL basic_head: got v=%b data=%h fe=%b pe=%b lvl=%0d want 1 a5 0 0 1",
        ifa.rx_valid, ifa.rx_data, ifa.rx_ferror, ifa.rx_perror, level_a);
    end
    repeat (50) @(negedge clk);
    checks++;
    if ({ifa.rx_valid, ifa.rx_data} !== {1'b1, 8'hA5}) begin
      errors++; $display("FAIL basic_hold: got v=%b data=%h want 1 a5", ifa.rx_valid, ifa.rx_data);
    end
    ifa.rx_ready = 1'b1;
    @(negedge clk);
    ifa.rx_ready = 1'b0;
    checks++;
    if ({ifa.rx_valid, level_a} !== {1'b0, 3'd0}) begin
      errors++; $display("FAIL basic_pop: got v=%b lvl=%0d want 0 0", ifa.rx_valid, level_a);
    end
  endtask

  task automatic test_false_start;
    rxd = 1'b0;
    repeat (108) @(negedge clk);
    rxd = 1'b1;
    repeat (4500) @(negedge clk);
    checks++;
    if ({ifa.rx_valid, level_a, overrun_a} !== {1'b0, 3'd0, 1'b0}) begin
      errors++; $display("FAIL false_start: got v=%b lvl=%0d ovr=%b want 0 0 0", ifa.rx_valid, level_a, overrun_a);
    end
  endtask

  task automatic test_parity;
    logic ok, fe, pe;
    logic [7:0] d;
    parity_mode = 2'd1;
    send_frame(8'h03, 8, 1, 2'b11, 1);
    pop_entry(0, ok, d, fe, pe);
    checks++;
    if ({ok, d, fe, pe} !== {1'b1, 8'h03, 1'b0, 1'b1}) begin
      errors++; $display("FAIL even_bad: got ok=%b data=%h fe=%b pe=%b want 1 03 0 1", ok, d, fe, pe);
    end
    send_frame(8'h03, 8, 0, 2'b11, 1);
    pop_entry(0, ok, d, fe, pe);
    checks++;
    if ({ok, d, fe, pe} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
      errors++; $display("FAIL even_good: got ok=%b data=%h fe=%b pe=%b want 1 03 0 0", ok, d, fe, pe);
    end
    parity_mode = 2'd2;
    send_frame(8'h03, 8, 1, 2'b11, 1);
    pop_entry(0, ok, d, fe, pe);
    checks++;
    if ({ok, d, fe, pe} !== {1'b1, 8'h03, 1'b0, 1'b0}) begin
      errors++; $display("FAIL odd_good: got ok=%b data=%h fe=%b pe=%b want 1 03 0 0", ok, d, fe, pe);
    end
    parity_mode = 2'd0;
  endtask

  task automatic test_framing;
    logic ok, fe, pe;
    logic [7:0] d;
    send_frame(8'h5A, 8, -1, 2'b00, 1);
    pop_entry(0, ok, d, fe, pe);
    checks++;
    if ({ok, d, fe, pe} !== {1'b1, 8'h5A, 1'b1, 1'b0}) begin
      errors++; $display("FAIL frame_err: got ok=%b data=%h fe=%b pe=%b want 1 5a 1 0", ok, d, fe, pe);
    end
    send_frame(8'h11, 8, -1, 2'b11, 1);
    checks++;
    if ({ifa.rx_valid, ifa.rx_data, ifa.rx_ferror, ifa.rx_perror, level_a} !== {1'b1, 8'h11, 1'b0, 1'b0, 3'd1}) begin
      errors++; $display("FAIL after_ferr: got v=%b data=%h fe=%b lvl=%0d want 1 11 0 1",
        ifa.rx_valid, ifa.rx_data, ifa.rx_ferror, level_a);
    end
  endtask

  task automatic test_abort;
    drive_bits(16'b1010, 4);
    rx_en_a = 1'b0;
    rxd = 1'b1;
    @(negedge clk);
    rx_en_a = 1'b1;
    repeat (3000) @(negedge clk);
    checks++;
    if ({level_a, ifa.rx_data} !== {3'd1, 8'h11}) begin
      errors++; $display("FAIL abort: got lvl=%0d head=%h want 1 11", level_a, ifa.rx_data);
    end
  endtask

  task automatic test_reset_mid;
    logic ok, fe, pe;
    logic [7:0] d;
    drive_bits(16'b1010, 4);
    reset = 1'b0;
    #1;
    checks++;
    if ({ifa.rx_data, ifa.rx_ferror, ifa.rx_perror, ifa.rx_valid, overrun_a, level_a} !== '0) begin
      errors++; $display("FAIL reset_mid: got data=%h v=%b lvl=%0d want all 0", ifa.rx_data, ifa.rx_valid, level_a);
    end
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'hC3, 8, -1, 2'b11, 1);
    pop_entry(0, ok, d, fe, pe);
    checks++;
    if ({ok, d, fe, pe, level_a} !== {1'b1, 8'hC3, 1'b0, 1'b0, 3'd0}) begin
      errors++; $display("FAIL after_reset: got ok=%b data=%h fe=%b pe=%b lvl=%0d want 1 c3 0 0 0", ok, d, fe, pe, level_a);
    end
  endtask

  task automatic test_overrun;
    logic ok, fe, pe;
    logic [7:0] d;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 8, -1, 2'b11, 1);
    checks++;
    if ({level_a, overrun_a} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL fill: got lvl=%0d ovr=%b want 4 0", level_a, overrun_a);
    end
    fork
      send_frame(8'h05, 8, -1, 2'b11, 1);
      begin
        repeat (4160) @(negedge clk);
        ifa.rx_ready = 1'b1;
        @(negedge clk);
        ifa.rx_ready = 1'b0;
      end
    join
    checks++;
    if ({level_a, overrun_a} !== {3'd4, 1'b0}) begin
      errors++; $display("FAIL push_pop_full: got lvl=%0d ovr=%b want 4 0", level_a, overrun_a);
    end
    send_frame(8'h06, 8, -1, 2'b11, 1);
    checks++;
    if ({level_a, overrun_a} !== {3'd4, 1'b1}) begin
      errors++; $display("FAIL overrun: got lvl=%0d ovr=%b want 4 1", level_a, overrun_a);
    end
    for (int i = 2; i <= 5; i++) begin
      pop_entry(0, ok, d, fe, pe);
      checks++;
      if ({ok, d} !== {1'b1, 8'(i)}) begin
        errors++; $display("FAIL drain_%0d: got ok=%b data=%h want 1 %h", i, ok, d, 8'(i));
      end
    end
    ifa.rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    ifa.rx_ready = 1'b0;
    checks++;
    if ({ifa.rx_valid, level_a, overrun_a} !== {1'b0, 3'd0, 1'b1}) begin
      errors++; $display("FAIL empty_pop: got v=%b lvl=%0d ovr=%b want 0 0 1", ifa.rx_valid, level_a, overrun_a);
    end
    rx_en_a = 1'b0;
    @(negedge clk);
    rx_en_a = 1'b1;
    checks++;
    if (overrun_a !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b want 0", overrun_a); end
  endtask

  task automatic test_variant;
    logic ok, fe, pe;
    logic [7:0] d;
    rx_en_a = 1'b0;
    rx_en_b = 1'b1;
    repeat (4) @(negedge clk);
    send_frame(8'h55, 7, -1, 2'b11, 2);
    pop_entry(1, ok, d, fe, pe);
    checks++;
    if ({ok, d, fe, pe} !== {1'b1, 8'h55, 1'b0, 1'b0}) begin
      errors++; $display("FAIL b_55: got ok=%b data=%h fe=%b pe=%b want 1 55 0 0", ok, d, fe, pe);
    end
    send_frame(8'h2A, 7, -1, 2'b10, 2);
    pop_entry(1, ok, d, fe, pe);
    checks++;
    if ({ok, d, fe, pe} !== {1'b1, 8'h2A, 1'b1, 1'b0}) begin
      errors++; $display("FAIL b_stop1_err: got ok=%b data=%h fe=%b pe=%b want 1 2a 1 0", ok, d, fe, pe);
    end
  endtask

  initial begin
    ifa.rx_ready = 1'b0;
    ifb.rx_ready = 1'b0;
    test_reset();
    test_basic();
    test_false_start();
    test_parity();
    test_framing();
    test_abort();
    test_reset_mid();
    test_overrun();
    test_variant();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 200000 cycles");
    $fatal(1);
  end
endmodule
